// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: decoded control bundle, bubble constant,
// opcode/funct encodings and instruction field helpers.
package mips_pkg;

   // Decoded control bundle carried from ID into EX
   typedef struct packed {
      logic [2:0] PCSrc;
      logic [1:0] RegDst;
      logic       RegWr;
      logic       ALUSrc1;
      logic       ALUSrc2;
      logic [5:0] ALUFun;
      logic       Sign;
      logic       MemWr;
      logic       MemRd;
      logic [1:0] MemToReg;
      logic       LUOp;
      logic       Interrupt;
   } ctrl_t;

   // All-zero controls: no register write, no memory access, sequential PC
   localparam ctrl_t CTRL_BUBBLE = '0;

   // Primary opcodes
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_BLEZ  = 6'h06;
   localparam logic [5:0] OP_BGTZ  = 6'h07;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_SLTIU = 6'h0B;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   // R-type funct codes
   localparam logic [5:0] FN_SLL  = 6'h00;
   localparam logic [5:0] FN_SRL  = 6'h02;
   localparam logic [5:0] FN_SRA  = 6'h03;
   localparam logic [5:0] FN_JR   = 6'h08;
   localparam logic [5:0] FN_JALR = 6'h09;
   localparam logic [5:0] FN_ADD  = 6'h20;
   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUB  = 6'h22;
   localparam logic [5:0] FN_SUBU = 6'h23;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_XOR  = 6'h26;
   localparam logic [5:0] FN_NOR  = 6'h27;
   localparam logic [5:0] FN_SLT  = 6'h2A;
   localparam logic [5:0] FN_SLTU = 6'h2B;

   // Register-number fields of an instruction word
   function automatic logic [4:0] f_rs(input logic [31:0] instr);
      return instr[25:21];
   endfunction

   function automatic logic [4:0] f_rt(input logic [31:0] instr);
      return instr[20:16];
   endfunction

   function automatic logic [4:0] f_rd(input logic [31:0] instr);
      return instr[15:11];
   endfunction

   function automatic logic [4:0] f_shamt(input logic [31:0] instr);
      return instr[10:6];
   endfunction

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detection between the instruction in EX and the one in ID.
// Purely combinational; the pipeline register lives in id_ex_stage.
module hazard_detect
   import mips_pkg::*;
(
   input  logic       ex_mem_rd,
   input  logic       ex_valid,
   input  logic [4:0] ex_rt,
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic       id_interrupt,
   input  logic       flush,
   output logic       hazard,
   output logic       stall
);

   logic load_in_ex;
   logic rt_match;

   // rt is compared for every opcode: it may stall an I-type needlessly but
   // keeps the check independent of decode. Interrupts bypass the stall so
   // they are never delayed, and a redirect makes stalling pointless.
   always_comb begin
      load_in_ex = ex_mem_rd & ex_valid & (ex_rt != 5'd0);
      rt_match   = (ex_rt == id_rs) | (ex_rt == id_rt);
      hazard     = load_in_ex & rt_match & ~id_interrupt;
      stall      = hazard & ~flush;
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall generation, flush squashing
// and saturating stall/flush event counters.
module id_ex_stage
   import mips_pkg::*;
#(
   parameter int KER_BIT = 31,
   parameter int CNT_W   = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [31:0]       id_pc_plus4,
   input  logic [31:0]       id_instr,
   input  ctrl_t             id_ctrl,
   input  logic [31:0]       id_rs_data,
   input  logic [31:0]       id_rt_data,
   input  logic [31:0]       id_imm32,
   input  logic              flush,
   output ctrl_t             ex_ctrl,
   output logic [31:0]       ex_pc_plus4,
   output logic [31:0]       ex_rs_data,
   output logic [31:0]       ex_rt_data,
   output logic [31:0]       ex_imm32,
   output logic [4:0]        ex_rs,
   output logic [4:0]        ex_rt,
   output logic [4:0]        ex_rd,
   output logic [4:0]        ex_shamt,
   output logic              ex_valid,
   output logic              ex_ker,
   output logic              stall,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   // Everything held by the ID/EX register; an all-zero value is a bubble
   typedef struct packed {
      logic        valid;
      logic        ker;
      ctrl_t       ctrl;
      logic [31:0] pc_plus4;
      logic [31:0] rs_data;
      logic [31:0] rt_data;
      logic [31:0] imm32;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [4:0]  shamt;
   } ex_regs_t;

   localparam ex_regs_t   EX_BUBBLE = '0;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   ex_regs_t ex_q;
   ex_regs_t ex_d;
   logic     hazard;

   // Opcode and funct bits are not needed here; decode already consumed them
   logic unused_instr_bits;
   assign unused_instr_bits = ^{id_instr[31:26], id_instr[5:0]};

   hazard_detect u_hazard (
      .ex_mem_rd    (ex_q.ctrl.MemRd),
      .ex_valid     (ex_q.valid),
      .ex_rt        (ex_q.rt),
      .id_rs        (f_rs(id_instr)),
      .id_rt        (f_rt(id_instr)),
      .id_interrupt (id_ctrl.Interrupt),
      .flush        (flush),
      .hazard       (hazard),
      .stall        (stall)
   );

   // Next register value: flush and hazard both insert a bubble, else capture
   always_comb begin
      ex_d          = EX_BUBBLE;
      ex_d.valid    = 1'b1;
      ex_d.ker      = id_pc_plus4[KER_BIT];
      ex_d.ctrl     = id_ctrl;
      ex_d.pc_plus4 = id_pc_plus4;
      ex_d.rs_data  = id_rs_data;
      ex_d.rt_data  = id_rt_data;
      ex_d.imm32    = id_imm32;
      ex_d.rs       = f_rs(id_instr);
      ex_d.rt       = f_rt(id_instr);
      ex_d.rd       = f_rd(id_instr);
      ex_d.shamt    = f_shamt(id_instr);
      if (flush || hazard) begin
         ex_d = EX_BUBBLE;
      end
   end

   // ID/EX pipeline register; reset loads a bubble without waiting for clk
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ex_q <= EX_BUBBLE;
      end else begin
         ex_q <= ex_d;
      end
   end

   // Saturating event counters for stall and flush cycles
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (stall && stall_cnt != CNT_MAX) begin
            stall_cnt <= stall_cnt + CNT_ONE;
         end
         if (flush && flush_cnt != CNT_MAX) begin
            flush_cnt <= flush_cnt + CNT_ONE;
         end
      end
   end

   assign ex_valid    = ex_q.valid;
   assign ex_ker      = ex_q.ker;
   assign ex_ctrl     = ex_q.ctrl;
   assign ex_pc_plus4 = ex_q.pc_plus4;
   assign ex_rs_data  = ex_q.rs_data;
   assign ex_rt_data  = ex_q.rt_data;
   assign ex_imm32    = ex_q.imm32;
   assign ex_rs       = ex_q.rs;
   assign ex_rt       = ex_q.rt;
   assign ex_rd       = ex_q.rd;
   assign ex_shamt    = ex_q.shamt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: scoreboard of expected EX contents per step,
// immediate-assertion checks of stall, outputs and counters.
module tb_id_ex_stage;
   import mips_pkg::*;

   typedef struct packed {
      logic        valid;
      logic        ker;
      ctrl_t       ctrl;
      logic [31:0] pc;
      logic [31:0] rs_data;
      logic [31:0] rt_data;
      logic [31:0] imm;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [4:0]  shamt;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] id_pc_plus4, id_instr, id_rs_data, id_rt_data, id_imm32;
   ctrl_t       id_ctrl;
   logic        flush;

   ctrl_t       ex_ctrl, s_ex_ctrl;
   logic [31:0] ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm32;
   logic [31:0] s_ex_pc_plus4, s_ex_rs_data, s_ex_rt_data, s_ex_imm32;
   logic [4:0]  ex_rs, ex_rt, ex_rd, ex_shamt;
   logic [4:0]  s_ex_rs, s_ex_rt, s_ex_rd, s_ex_shamt;
   logic        ex_valid, ex_ker, stall, s_ex_valid, s_ex_ker, s_stall;
   logic [15:0] stall_cnt, flush_cnt;
   logic [2:0]  s_stall_cnt, s_flush_cnt;

   int   n_chk = 0;
   int   n_pass = 0;
   int   exp_sc = 0;
   int   exp_fc = 0;
   exp_t sb[$];
   ctrl_t c_lw, c_add, c_sw, c_irq;

   always #5 clk = ~clk;

   id_ex_stage #(.KER_BIT(31), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .id_pc_plus4(id_pc_plus4), .id_instr(id_instr),
      .id_ctrl(id_ctrl), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
      .id_imm32(id_imm32), .flush(flush), .ex_ctrl(ex_ctrl), .ex_pc_plus4(ex_pc_plus4),
      .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm32(ex_imm32),
      .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_shamt(ex_shamt),
      .ex_valid(ex_valid), .ex_ker(ex_ker), .stall(stall),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   // Narrow-counter copy sharing the same stimulus, to reach saturation quickly
   id_ex_stage #(.KER_BIT(31), .CNT_W(3)) dut_small (
      .clk(clk), .reset(reset), .id_pc_plus4(id_pc_plus4), .id_instr(id_instr),
      .id_ctrl(id_ctrl), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
      .id_imm32(id_imm32), .flush(flush), .ex_ctrl(s_ex_ctrl), .ex_pc_plus4(s_ex_pc_plus4),
      .ex_rs_data(s_ex_rs_data), .ex_rt_data(s_ex_rt_data), .ex_imm32(s_ex_imm32),
      .ex_rs(s_ex_rs), .ex_rt(s_ex_rt), .ex_rd(s_ex_rd), .ex_shamt(s_ex_shamt),
      .ex_valid(s_ex_valid), .ex_ker(s_ex_ker), .stall(s_stall),
      .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
   );

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_chk++;
      assert (got === exp) n_pass++;
      else $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   function automatic int sat(input int v, input int mx);
      return (v > mx) ? mx : v;
   endfunction

   function automatic logic [31:0] mk_r(input int rs, input int rt, input int rd, input logic [5:0] fn);
      return {OP_RTYPE, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
   endfunction

   function automatic logic [31:0] mk_i(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
      return {op, 5'(rs), 5'(rt), imm};
   endfunction

   function automatic exp_t got_now();
      return {ex_valid, ex_ker, ex_ctrl, ex_pc_plus4, ex_rs_data, ex_rt_data,
              ex_imm32, ex_rs, ex_rt, ex_rd, ex_shamt};
   endfunction

   task automatic chk_cnt(input string tag);
      chk({tag, ".stall_cnt"}, 256'(stall_cnt), 256'(sat(exp_sc, 65535)));
      chk({tag, ".flush_cnt"}, 256'(flush_cnt), 256'(sat(exp_fc, 65535)));
      chk({tag, ".s_stall_cnt"}, 256'(s_stall_cnt), 256'(sat(exp_sc, 7)));
      chk({tag, ".s_flush_cnt"}, 256'(s_flush_cnt), 256'(sat(exp_fc, 7)));
   endtask

   // One clock step: drive ID, check stall mid-cycle, push the expected EX
   // contents, then pop and compare just after the edge.
   task automatic step(input string tag, input logic [31:0] instr, input ctrl_t c,
                       input logic [31:0] pc, input logic fl,
                       input logic exp_stall, input logic exp_bubble);
      exp_t e;
      exp_t g;
      id_instr    = instr;
      id_ctrl     = c;
      id_pc_plus4 = pc;
      id_rs_data  = $urandom;
      id_rt_data  = $urandom;
      id_imm32    = {{16{instr[15]}}, instr[15:0]};
      flush       = fl;
      @(negedge clk);
      chk({tag, ".stall"}, 256'(stall), 256'(exp_stall));
      e = '0;
      if (!exp_bubble) begin
         e = {1'b1, pc[31], c, pc, id_rs_data, id_rt_data, id_imm32,
              instr[25:21], instr[20:16], instr[15:11], instr[10:6]};
      end
      sb.push_back(e);
      if (exp_stall) exp_sc++;
      if (fl) exp_fc++;
      @(posedge clk);
      #1;
      g = got_now();
      chk({tag, ".ex"}, 256'(g), 256'(sb.pop_front()));
      chk_cnt(tag);
   endtask

   initial begin
      c_lw  = '0; c_lw.RegWr = 1'b1; c_lw.ALUSrc2 = 1'b1; c_lw.MemRd = 1'b1; c_lw.MemToReg = 2'd1;
      c_add = '0; c_add.RegDst = 2'd1; c_add.RegWr = 1'b1; c_add.Sign = 1'b1;
      c_sw  = '0; c_sw.ALUSrc2 = 1'b1; c_sw.MemWr = 1'b1;
      c_irq = c_add; c_irq.Interrupt = 1'b1; c_irq.PCSrc = 3'd4;

      // Reset with a would-be dependent instruction on ID
      reset = 1'b1; flush = 1'b0; id_ctrl = c_add; id_instr = mk_r(8, 11, 10, FN_ADD);
      id_pc_plus4 = 32'h0040_0000; id_rs_data = 32'h1; id_rt_data = 32'h2; id_imm32 = 32'h3;
      #1;
      chk("reset.ex", 256'(got_now()), 256'(0));
      chk("reset.stall", 256'(stall), 256'(0));
      chk_cnt("reset");
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;

      // lw $8,0($9) ; add $10,$8,$11 -> one stall, bubble, then add captured
      step("lw1", mk_i(OP_LW, 9, 8, 16'h0), c_lw, 32'h0040_0004, 1'b0, 1'b0, 1'b0);
      step("add_stall", mk_r(8, 11, 10, FN_ADD), c_add, 32'h0040_0008, 1'b0, 1'b1, 1'b1);
      step("add_cap", mk_r(8, 11, 10, FN_ADD), c_add, 32'h0040_0008, 1'b0, 1'b0, 1'b0);
      chk("add_cap.ex_rs", 256'(ex_rs), 256'(8));

      // Load into $0 never stalls
      step("lw0", mk_i(OP_LW, 9, 0, 16'h4), c_lw, 32'h0040_000C, 1'b0, 1'b0, 1'b0);
      step("add0", mk_r(0, 11, 10, FN_ADD), c_add, 32'h0040_0010, 1'b0, 1'b0, 1'b0);

      // Dependency through the rt field (store data) stalls
      step("lw2", mk_i(OP_LW, 9, 8, 16'hFFFC), c_lw, 32'h0040_0014, 1'b0, 1'b0, 1'b0);
      step("sw_stall", mk_i(OP_SW, 9, 8, 16'h8), c_sw, 32'h0040_0018, 1'b0, 1'b1, 1'b1);
      step("sw_cap", mk_i(OP_SW, 9, 8, 16'h8), c_sw, 32'h0040_0018, 1'b0, 1'b0, 1'b0);

      // Hazard and flush together: no stall, bubble, flush counted
      step("lw3", mk_i(OP_LW, 9, 8, 16'h0), c_lw, 32'h0040_001C, 1'b0, 1'b0, 1'b0);
      step("haz_flush", mk_r(8, 11, 10, FN_ADD), c_add, 32'h0040_0020, 1'b1, 1'b0, 1'b1);

      // Interrupt on a dependent instruction is captured at once (kernel PC)
      step("lw4", mk_i(OP_LW, 9, 8, 16'h0), c_lw, 32'h0040_0024, 1'b0, 1'b0, 1'b0);
      step("irq", mk_r(8, 11, 10, FN_ADD), c_irq, 32'h8000_0184, 1'b0, 1'b0, 1'b0);
      chk("irq.Interrupt", 256'(ex_ctrl.Interrupt), 256'(1));
      chk("irq.ex_ker", 256'(ex_ker), 256'(1));

      // Reset asserted between edges while a stall is pending
      step("lw5", mk_i(OP_LW, 9, 8, 16'h0), c_lw, 32'h0040_0028, 1'b0, 1'b0, 1'b0);
      id_instr = mk_r(8, 11, 10, FN_ADD); id_ctrl = c_add; id_pc_plus4 = 32'h0040_002C;
      @(negedge clk);
      chk("mid.stall_before", 256'(stall), 256'(1));
      #1 reset = 1'b1;
      #1;
      chk("mid.ex", 256'(got_now()), 256'(0));
      chk("mid.stall", 256'(stall), 256'(0));
      exp_sc = 0; exp_fc = 0;
      chk_cnt("mid");
      #1 reset = 1'b0;
      @(posedge clk);
      #1;
      chk("mid.recap_valid", 256'(ex_valid), 256'(1));
      chk("mid.recap_rs", 256'(ex_rs), 256'(8));
      chk("mid.recap_regwr", 256'(ex_ctrl.RegWr), 256'(1));
      chk_cnt("mid.recap");

      // Repeated load-use pairs push the 3-bit stall counter into saturation
      for (int i = 0; i < 10; i++) begin
         step("sat_lw", mk_i(OP_LW, 9, 8, 16'h0), c_lw, 32'h0040_0100, 1'b0, 1'b0, 1'b0);
         step("sat_stall", mk_r(11, 8, 10, FN_ADD), c_add, 32'h0040_0104, 1'b0, 1'b1, 1'b1);
         step("sat_cap", mk_r(11, 8, 10, FN_ADD), c_add, 32'h0040_0104, 1'b0, 1'b0, 1'b0);
      end

      // Long flush: 16-bit flush counter saturates, no wrap
      step("lw6", mk_i(OP_LW, 9, 8, 16'h0), c_lw, 32'h0040_0200, 1'b0, 1'b0, 1'b0);
      id_instr = mk_r(8, 11, 10, FN_ADD); id_ctrl = c_add; flush = 1'b1;
      for (int i = 0; i < 65540; i++) begin
         @(negedge clk);
         if (i == 0) chk("long.stall", 256'(stall), 256'(0));
         exp_fc++;
      end
      @(posedge clk);
      #1;
      chk("long.ex", 256'(got_now()), 256'(0));
      chk("long.flush_cnt_max", 256'(flush_cnt), 256'(16'hFFFF));
      chk_cnt("long");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
